// File: rtl/spike_rate_decoder.sv
// spike_rate_decoder
// Counts rising edges on each spike line over a window of WINDOW enabled
// cycles. Each closed window is latched into an output register with the
// index of the busiest channel, and is offered downstream on a valid/ready
// handshake. A sticky overrun flag records windows that were dropped because
// the previous result had not been taken yet.
module spike_rate_decoder #(
  parameter int CHANNELS = 4,
  parameter int WINDOW   = 16,
  parameter int CNT_W    = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic [CHANNELS-1:0]           spike_in,
  input  logic                          clr_overrun,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [CHANNELS*CNT_W-1:0]     rate_out,
  output logic [$clog2(CHANNELS)-1:0]   winner,
  output logic                          overrun
);

  localparam int WIN_W = $clog2(CHANNELS);
  localparam int WC_W  = (WINDOW > 2) ? $clog2(WINDOW) : 1;

  localparam logic [WC_W-1:0]  WIN_LAST = WC_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  // ---------------------------------------------------------------------
  // Edge detection and window position
  // ---------------------------------------------------------------------
  logic [CHANNELS-1:0] prev_spike_q;
  logic [CHANNELS-1:0] spike_edge;
  logic [WC_W-1:0]     win_cnt_q;
  logic [WC_W-1:0]     win_cnt_d;
  logic                win_close;

  // A line counts only on its 0->1 transition. The history tracks the
  // input on every cycle, including frozen ones, so an edge that happens
  // while counting is paused is consumed and never counted afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_spike_q <= '0;
    end else begin
      prev_spike_q <= spike_in;
    end
  end

  assign spike_edge = spike_in & ~prev_spike_q;

  // The close cycle is the last enabled cycle of the window; edges seen on
  // that cycle still belong to the closing window.
  assign win_close = enable && (win_cnt_q == WIN_LAST);

  // Window position advances only on enabled cycles and wraps at close so
  // the next window starts immediately.
  always_comb begin
    win_cnt_d = win_cnt_q;
    if (enable) begin
      if (win_close) begin
        win_cnt_d = '0;
      end else begin
        win_cnt_d = win_cnt_q + 1'b1;
      end
    end
  end

  // Window position register.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_cnt_q <= '0;
    end else begin
      win_cnt_q <= win_cnt_d;
    end
  end

  // ---------------------------------------------------------------------
  // Per-channel saturating counters
  // ---------------------------------------------------------------------
  // cnt_next_bus holds every counter's post-increment value. It is both the
  // next state during a window and the closing result on the close cycle.
  logic [CHANNELS*CNT_W-1:0] cnt_next_bus;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] cnt_d;

    // Increment on an edge, pinning at the top of the range.
    always_comb begin
      cnt_inc = cnt_q;
      if (spike_edge[gi] && (cnt_q != CNT_MAX)) begin
        cnt_inc = cnt_q + 1'b1;
      end
    end

    // Counters hold while frozen and restart from zero after a close.
    always_comb begin
      cnt_d = cnt_q;
      if (enable) begin
        if (win_close) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
    end

    // Channel counter register.
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign cnt_next_bus[gi*CNT_W +: CNT_W] = cnt_inc;
  end

  // ---------------------------------------------------------------------
  // Winner selection over the closing counts
  // ---------------------------------------------------------------------
  logic [WIN_W-1:0] best_idx;
  logic [CNT_W-1:0] best_cnt;

  // Strictly-greater comparison in ascending order keeps the lowest index
  // on ties, and leaves index 0 when every count is zero.
  always_comb begin
    best_idx = '0;
    best_cnt = cnt_next_bus[0 +: CNT_W];
    for (int i = 1; i < CHANNELS; i++) begin
      if (cnt_next_bus[i*CNT_W +: CNT_W] > best_cnt) begin
        best_cnt = cnt_next_bus[i*CNT_W +: CNT_W];
        best_idx = WIN_W'(i);
      end
    end
  end

  // ---------------------------------------------------------------------
  // Output register, handshake and overrun
  // ---------------------------------------------------------------------
  logic                      out_valid_q;
  logic                      out_valid_d;
  logic [CHANNELS*CNT_W-1:0] rate_q;
  logic [CHANNELS*CNT_W-1:0] rate_d;
  logic [WIN_W-1:0]          winner_q;
  logic [WIN_W-1:0]          winner_d;
  logic                      overrun_q;
  logic                      overrun_d;
  logic                      xfer;
  logic                      load;
  logic                      drop;

  assign xfer = out_valid_q && out_ready;
  // A new result may enter when the slot is empty or being emptied now.
  assign load = win_close && (!out_valid_q || out_ready);
  // Otherwise the new result is lost and the held one is kept intact.
  assign drop = win_close && out_valid_q && !out_ready;

  // Next-state for the result slot; stale data is left in place after a
  // transfer so only out_valid changes.
  always_comb begin
    out_valid_d = out_valid_q;
    rate_d      = rate_q;
    winner_d    = winner_q;
    if (load) begin
      out_valid_d = 1'b1;
      rate_d      = cnt_next_bus;
      winner_d    = best_idx;
    end else if (xfer) begin
      out_valid_d = 1'b0;
    end
  end

  // Sticky overrun: a drop in the same cycle as a clear request wins.
  always_comb begin
    overrun_d = overrun_q;
    if (drop) begin
      overrun_d = 1'b1;
    end else if (clr_overrun) begin
      overrun_d = 1'b0;
    end
  end

  // Result slot and overrun registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      rate_q      <= '0;
      winner_q    <= '0;
      overrun_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      rate_q      <= rate_d;
      winner_q    <= winner_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_valid = out_valid_q;
  assign rate_out  = rate_q;
  assign winner    = winner_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Directed bench for spike_rate_decoder: a table of single-window spike
// patterns with hand-counted results, then hand-written sequences for the
// handshake, overrun, freeze, reset and saturation corner cases.
module tb_spike_rate_decoder;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [3:0]  spike_in;
  logic        clr_overrun;
  logic        out_ready;

  logic        out_valid;
  logic [15:0] rate_out;
  logic [1:0]  winner;
  logic        overrun;

  logic        v64_valid;
  logic [15:0] v64_rate;
  logic [1:0]  v64_winner;
  logic        v64_overrun;

  int checks;
  int errors;

  spike_rate_decoder #(.CHANNELS(4), .WINDOW(16), .CNT_W(4)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .spike_in   (spike_in),
    .clr_overrun(clr_overrun),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .rate_out   (rate_out),
    .winner     (winner),
    .overrun    (overrun)
  );

  spike_rate_decoder #(.CHANNELS(4), .WINDOW(64), .CNT_W(4)) u_dut64 (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .spike_in   (spike_in),
    .clr_overrun(clr_overrun),
    .out_valid  (v64_valid),
    .out_ready  (out_ready),
    .rate_out   (v64_rate),
    .winner     (v64_winner),
    .overrun    (v64_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string            name;
    logic [3:0][15:0] pat;      // pat[ch][t] = spike_in[ch] on window cycle t
    logic [15:0]      exp_rate;
    logic [1:0]       exp_win;
  } vec_t;

  vec_t vecs [5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    enable      = 1'b1;
    spike_in    = 4'b0000;
    clr_overrun = 1'b0;
    out_ready   = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  // One full 16-cycle window; out_ready / clr_overrun only on the close cycle.
  task automatic run_window(input logic [3:0][15:0] pat, input logic ready_last,
                            input logic clr_last);
    enable = 1'b1;
    for (int t = 0; t < 16; t++) begin
      for (int c = 0; c < 4; c++) spike_in[c] = pat[c][t];
      out_ready   = (t == 15) ? ready_last : 1'b0;
      clr_overrun = (t == 15) ? clr_last : 1'b0;
      tick();
    end
    out_ready   = 1'b0;
    clr_overrun = 1'b0;
  endtask

  initial begin
    logic [3:0][15:0] p;
    checks = 0;
    errors = 0;

    // ch order in pat: {ch3, ch2, ch1, ch0}
    vecs[0] = '{"pulses_held", {16'h0000, 16'h0000, 16'hFFFF, 16'h2222}, 16'h0014, 2'd0};
    vecs[1] = '{"all_zero",    {16'h0000, 16'h0000, 16'h0000, 16'h0000}, 16'h0000, 2'd0};
    vecs[2] = '{"tie_close",   {16'hAAAA, 16'h8000, 16'h5555, 16'h000F}, 16'h8181, 2'd1};
    vecs[3] = '{"ch3_wins",    {16'h0111, 16'h0F0F, 16'h0000, 16'h0001}, 16'h3201, 2'd3};
    vecs[4] = '{"tie_ch2",     {16'h1111, 16'h3333, 16'h0011, 16'h0101}, 16'h4422, 2'd2};

    // Reset state
    do_reset();
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_rate", {16'd0, rate_out}, 32'd0);
    check("rst_winner", {30'd0, winner}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);

    // Table: one window per vector from a fresh reset
    for (int v = 0; v < 5; v++) begin
      do_reset();
      run_window(vecs[v].pat, 1'b0, 1'b0);
      $display("vec %s valid=%0b rate=%h winner=%0d", vecs[v].name, out_valid, rate_out, winner);
      check({vecs[v].name, "_valid"}, {31'd0, out_valid}, 32'd1);
      check({vecs[v].name, "_rate"}, {16'd0, rate_out}, {16'd0, vecs[v].exp_rate});
      check({vecs[v].name, "_winner"}, {30'd0, winner}, {30'd0, vecs[v].exp_win});
      check({vecs[v].name, "_overrun"}, {31'd0, overrun}, 32'd0);
    end

    // Overrun: hold first result through a second close; clear collides with drop
    do_reset();
    run_window(vecs[0].pat, 1'b0, 1'b0);
    check("ovr_first_valid", {31'd0, out_valid}, 32'd1);
    check("ovr_first_flag", {31'd0, overrun}, 32'd0);
    run_window(vecs[2].pat, 1'b0, 1'b1);
    $display("overrun seq: valid=%0b rate=%h overrun=%0b", out_valid, rate_out, overrun);
    check("ovr_held_rate", {16'd0, rate_out}, 32'h0014);
    check("ovr_held_winner", {30'd0, winner}, 32'd0);
    check("ovr_held_valid", {31'd0, out_valid}, 32'd1);
    check("ovr_set_wins", {31'd0, overrun}, 32'd1);
    enable      = 1'b0;
    clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;
    check("ovr_cleared", {31'd0, overrun}, 32'd0);
    check("ovr_still_valid", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("xfer_valid_low", {31'd0, out_valid}, 32'd0);
    check("xfer_stale_rate", {16'd0, rate_out}, 32'h0014);

    // Ready exactly on the close cycle: new result replaces the held one
    do_reset();
    run_window(vecs[0].pat, 1'b0, 1'b0);
    p = {16'h0001, 16'h0000, 16'h0000, 16'h0000};
    run_window(p, 1'b1, 1'b0);
    $display("ready_on_close: valid=%0b rate=%h winner=%0d overrun=%0b", out_valid, rate_out, winner, overrun);
    check("roc_valid", {31'd0, out_valid}, 32'd1);
    check("roc_rate", {16'd0, rate_out}, 32'h1000);
    check("roc_winner", {30'd0, winner}, 32'd3);
    check("roc_overrun", {31'd0, overrun}, 32'd0);

    // Freeze mid-window: ch3 edges while frozen are never counted
    do_reset();
    p = {16'hFF00, 16'h1500, 16'h0015, 16'h0000};
    for (int t = 0; t < 8; t++) begin
      for (int c = 0; c < 4; c++) spike_in[c] = p[c][t];
      tick();
    end
    enable = 1'b0;
    for (int f = 0; f < 5; f++) begin
      spike_in = {((f == 1) || (f == 3) || (f == 4)), 3'b000};
      tick();
    end
    check("frz_no_close", {31'd0, out_valid}, 32'd0);
    enable = 1'b1;
    for (int t = 8; t < 16; t++) begin
      for (int c = 0; c < 4; c++) spike_in[c] = p[c][t];
      tick();
      if (t == 14) check("frz_pre_close", {31'd0, out_valid}, 32'd0);
    end
    $display("freeze: valid=%0b rate=%h winner=%0d", out_valid, rate_out, winner);
    check("frz_valid", {31'd0, out_valid}, 32'd1);
    check("frz_rate", {16'd0, rate_out}, 32'h0330);
    check("frz_winner", {30'd0, winner}, 32'd1);

    // Reset at window cycle 8 discards the partial window
    do_reset();
    for (int t = 0; t < 8; t++) begin
      spike_in = {3'b000, ~t[0]};
      tick();
    end
    rst      = 1'b1;
    spike_in = 4'b0001;
    tick();
    rst = 1'b0;
    check("mrst_valid", {31'd0, out_valid}, 32'd0);
    check("mrst_rate", {16'd0, rate_out}, 32'd0);
    p = {16'h0000, 16'h0100, 16'h0000, 16'h0005};
    for (int t = 0; t < 16; t++) begin
      for (int c = 0; c < 4; c++) spike_in[c] = p[c][t];
      tick();
      if (t == 14) check("mrst_pre_close", {31'd0, out_valid}, 32'd0);
    end
    $display("mid_reset: valid=%0b rate=%h winner=%0d", out_valid, rate_out, winner);
    check("mrst_res_valid", {31'd0, out_valid}, 32'd1);
    check("mrst_res_rate", {16'd0, rate_out}, 32'h0102);
    check("mrst_res_winner", {30'd0, winner}, 32'd0);

    // WINDOW=64: ch2 toggles every cycle (32 edges) and saturates at 15
    do_reset();
    for (int t = 0; t < 64; t++) begin
      spike_in = {1'b0, ~t[0], 1'b0, (t < 3)};
      tick();
      if (t == 62) check("sat_pre_close", {31'd0, v64_valid}, 32'd0);
    end
    $display("saturate: valid=%0b rate=%h winner=%0d", v64_valid, v64_rate, v64_winner);
    check("sat_valid", {31'd0, v64_valid}, 32'd1);
    check("sat_rate", {16'd0, v64_rate}, 32'h0F01);
    check("sat_winner", {30'd0, v64_winner}, 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
